hex_scan: RTL and testbench
===========================

HEX_SCAN -- requirements
Module: hex_scan

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed display digits (legal 2..8).
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each digit is driven per scan step (legal >= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers a new display word.
REQ-006 in_data  input  4*DIGITS  display word; nibble k (bits 4k+3:4k) is digit k.
REQ-007 in_blank  input  DIGITS  per-digit blank mask, captured with in_data; bit k=1 blanks digit k.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 bcd  output  4  nibble of the currently scanned digit, to the hex segment decoder.
REQ-010 digit_en_n  output  DIGITS  active-low digit enables, at most one bit low.
REQ-011 frame_done  output  1  one-cycle pulse marking start of a new scan frame.

Function
REQ-012 Transfer occurs on a rising edge where in_valid=1 and in_ready=1; in_data/in_blank are then captured into a pending buffer and pending flag set.
REQ-013 in_ready SHALL equal NOT pending flag (single-entry buffer); in_valid while in_ready=0 is ignored and the producer must hold its word.
REQ-014 Prescaler counts 0..SCAN_DIV-1, wrapping to 0; tick is asserted in the cycle the prescaler equals SCAN_DIV-1.
REQ-015 Digit index idx (width clog2(DIGITS), min 1) increments on tick, wrapping DIGITS-1 -> 0.
REQ-016 Frame boundary = tick AND idx=DIGITS-1.
REQ-017 At a frame boundary with pending=1: active word <= pending word, active mask <= pending mask, pending <= 0, all on the same edge idx wraps to 0.
REQ-018 At a frame boundary with pending=0: active word and mask unchanged.
REQ-019 A transfer accepted in a boundary cycle (pending was 0) sets pending and is applied at the next boundary, not the current one.
REQ-020 Displayed data never changes mid-frame; digits 0..DIGITS-1 of one frame always come from one word.
REQ-021 bcd = active word nibble idx; driven from registered state only, no combinational path from in_* inputs.
REQ-022 digit_en_n = all ones except bit idx low; if active mask bit idx = 1, digit_en_n = all ones (bcd still driven).
REQ-023 frame_done is registered: high for exactly one cycle, the cycle after each frame boundary (idx=0, prescaler=0).
REQ-024 Full frame period = DIGITS*SCAN_DIV cycles; frame_done pulses exactly that far apart.
REQ-025 Scanning runs continuously from reset release; no enable input.

Reset
REQ-026 While rst_n=0, asynchronously: prescaler=0, idx=0, active word=0, active mask=0, pending=0, frame_done=0.
REQ-027 Resulting output values during reset: in_ready=1, bcd=4'h0, digit_en_n=~1 (only bit 0 low), frame_done=0.
REQ-028 Reset asserted mid-frame or with a pending word discards the pending word and restarts scanning at digit 0 on release; first frame_done occurs DIGITS*SCAN_DIV cycles after release.

Verification (DIGITS=8, SCAN_DIV=4)
REQ-029 Reset release, no input -> bcd=0 throughout, digit_en_n steps FE,FD,FB..7F every 4 cycles, frame_done first at cycle 32, then every 32.
REQ-030 Transfer in_data=32'h76543210, in_blank=0 at cycle 5 -> in_ready low from cycle 6, digits keep showing 0 until frame_done, then bcd shows 0,1,2..7 on digits 0..7, in_ready high again same edge.
REQ-031 Second transfer attempted while pending=1 -> in_ready=0, word not captured; producer holds; captured on first cycle after boundary, shown one frame later.
REQ-032 Transfer presented exactly in boundary cycle with pending=0 -> accepted, applied at following boundary (32 cycles later), not immediately.
REQ-033 in_blank=8'h81 with word 32'hFEDCBA98 -> digit_en_n all ones during idx 0 and idx 7, normal one-hot low for idx 1..6 with bcd 9..E.
REQ-034 rst_n pulsed low during idx=5 with pending=1 -> outputs immediately at reset values, pending word lost, in_ready=1, display shows 0.

Source files
------------

// File: rtl/hex_scan.sv
// Multiplexed hex display scanner: time-slices a 4*DIGITS-bit word across DIGITS digits.
// A single-entry pending buffer accepts new words, which are applied only at frame boundaries.
module hex_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_blank,
  output logic                  in_ready,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [4*DIGITS-1:0]   pend_word_q, pend_word_d;
  logic [DIGITS-1:0]     pend_mask_q, pend_mask_d;
  logic [4*DIGITS-1:0]   act_word_q, act_word_d;
  logic [DIGITS-1:0]     act_mask_q, act_mask_d;
  logic                  frame_done_q, frame_done_d;

  logic tick;
  logic boundary;
  logic accept;

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);
  assign in_ready = ~pend_q;
  assign accept   = in_valid && ~pend_q;

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_word_d  = pend_word_q;
    pend_mask_d  = pend_mask_q;
    act_word_d   = act_word_q;
    act_mask_d   = act_mask_q;
    frame_done_d = boundary;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Pending can only be applied or filled, never both: accept requires pend_q=0.
    if (boundary && pend_q) begin
      act_word_d = pend_word_q;
      act_mask_d = pend_mask_q;
      pend_d     = 1'b0;
    end

    if (accept) begin
      pend_d      = 1'b1;
      pend_word_d = in_data;
      pend_mask_d = in_blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_word_q  <= '0;
      pend_mask_q  <= '0;
      act_word_q   <= '0;
      act_mask_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_word_q  <= pend_word_d;
      pend_mask_q  <= pend_mask_d;
      act_word_q   <= act_word_d;
      act_mask_q   <= act_mask_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    bcd        = 4'h0;
    digit_en_n = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        bcd           = act_word_q[4*k +: 4];
        digit_en_n[k] = act_mask_q[k];
      end
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan.sv
// Self-checking bench for hex_scan (DIGITS=8, SCAN_DIV=4) against a cycle-count based model.
module tb_hex_scan;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic [4*DIGITS-1:0] in_data;
  logic [DIGITS-1:0]   in_blank;
  logic                in_ready;
  logic [3:0]          bcd;
  logic [DIGITS-1:0]   digit_en_n;
  logic                frame_done;

  hex_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_blank   (in_blank),
    .in_ready   (in_ready),
    .bcd        (bcd),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: cycles since reset release plus the two buffered words.
  int           cyc;
  logic [31:0]  m_act;
  logic [7:0]   m_amask;
  logic [31:0]  m_pw;
  logic [7:0]   m_pmask;
  bit           m_pend;
  bit           m_fd;
  bit           m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int d;
    logic [7:0] en;
    d  = (cyc / SCAN_DIV) % DIGITS;
    en = m_amask[d] ? 8'hFF : ~(8'h01 << d);
    chk("in_ready",   32'(in_ready),   32'(!m_pend));
    chk("bcd",        32'(bcd),        32'(4'(m_act >> (4*d))));
    chk("digit_en_n", 32'(digit_en_n), 32'(en));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic model_reset();
    cyc = 0; m_act = '0; m_amask = '0; m_pw = '0; m_pmask = '0;
    m_pend = 0; m_fd = 0; m_acc = 0;
  endtask

  task automatic cycle();
    bit last;
    @(posedge clk);
    last  = ((cyc % FRAME) == FRAME - 1);
    m_acc = in_valid && !m_pend;
    if (last && m_pend) begin
      m_act = m_pw; m_amask = m_pmask; m_pend = 0;
    end
    if (m_acc) begin
      m_pend = 1; m_pw = in_data; m_pmask = in_blank;
    end
    m_fd = last;
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Producer holds the word until it is taken; bounded wait.
  task automatic send(input logic [31:0] data, input logic [7:0] blank);
    int budget;
    budget   = 4 * FRAME;
    in_valid = 1'b1; in_data = data; in_blank = blank;
    m_acc    = 0;
    while (!m_acc && budget > 0) begin
      cycle();
      budget--;
    end
    n_assert++;
    assert (m_acc) else begin
      n_fail++;
      $error("FAIL send_timeout observed=%0d expected=1", m_acc);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(in_ready),   32'd1);
    chk({tag, "_bcd"},   32'(bcd),        32'd0);
    chk({tag, "_en"},    32'(digit_en_n), 32'h0000_00FE);
    chk({tag, "_fd"},    32'(frame_done), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int fd_seen;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_blank = '0;
    model_reset();
    #2;
    apply_reset();

    // Idle scanning: frame_done first 32 cycles after release, then every 32.
    fd_seen = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      cycle();
      if (frame_done) fd_seen++;
      if (i == FRAME || i == 2 * FRAME) chk("fd_period", 32'(frame_done), 32'd1);
    end
    chk("fd_count_idle", 32'(fd_seen), 32'd2);

    // Plain word, then a second word offered while the first is pending.
    idle(5);
    send(32'h7654_3210, 8'h00);
    chk("ready_low_after_accept", 32'(in_ready), 32'd0);
    send(32'hFEDC_BA98, 8'h81);
    idle(2 * FRAME + 3);

    // Transfer presented exactly in a boundary cycle with nothing pending.
    while ((cyc % FRAME) != FRAME - 1) cycle();
    send(32'hA5A5_5A5A, 8'h10);
    chk("boundary_accept_pending", 32'(in_ready), 32'd0);
    idle(FRAME + 4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = $urandom;
      in_blank = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    idle(FRAME);

    // Reset during digit 5 with a pending word.
    send(32'h1357_9BDF, 8'h00);
    while (((cyc / SCAN_DIV) % DIGITS) != 5 || !m_pend) cycle();
    apply_reset();
    fd_seen = 0;
    for (int i = 1; i <= FRAME; i++) begin
      cycle();
      if (frame_done) fd_seen++;
    end
    chk("fd_after_reset_at_32", 32'(frame_done), 32'd1);
    chk("fd_count_after_reset", 32'(fd_seen), 32'd1);
    idle(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
